// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS tone generator: steps f_sel from a latched
// low to high bound with a programmable dwell per step and optional enable-low gaps.
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16,
  parameter int GAP_CYC = 0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         sel_lo,
  input  logic [2:0]         sel_hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  output logic [2:0]         f_sel,
  output logic               en,
  output logic               busy,
  output logic               step_strobe,
  output logic               done,
  output logic               err
);

  localparam int                GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC);
  localparam logic [2:0]        SEL_MAX  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cur_q, cur_d;
  logic [2:0]           lo_q, lo_d;
  logic [2:0]           hi_q, hi_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 loop_q, loop_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic [2:0]           f_sel_q, f_sel_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 strobe_q, strobe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 req_ok;

  assign req_ok = (sel_lo <= SEL_MAX) && (sel_hi <= SEL_MAX) &&
                  (sel_lo <= sel_hi) && (dwell != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      gap_q    <= '0;
      f_sel_q  <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      f_sel_q  <= f_sel_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dwell_d  = dwell_q;
    loop_d   = loop_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (req_ok) begin
            lo_d     = sel_lo;
            hi_d     = sel_hi;
            dwell_d  = dwell;
            loop_d   = loop;
            cur_d    = sel_lo;
            cnt_d    = DWELL_W'(1);
            strobe_d = 1'b1;
            state_d  = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          cur_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q) begin
          // cur never exceeds hi, so "not at hi" is the advance condition
          if ((cur_q != hi_q) || loop_q) begin
            cur_d = (cur_q != hi_q) ? cur_q + 3'd1 : lo_q;
            if (GAP_CYC > 0) begin
              state_d = S_GAP;
              gap_d   = GAP_W'(1);
              cnt_d   = '0;
            end else begin
              cnt_d    = DWELL_W'(1);
              strobe_d = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            cur_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          cur_d   = '0;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d  = S_RUN;
          gap_d    = '0;
          cnt_d    = DWELL_W'(1);
          strobe_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it
    en_d    = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    f_sel_d = busy_d ? cur_d : '0;
  end

  assign f_sel       = f_sel_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign step_strobe = strobe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: two instances (no gap, 2-cycle gap) share
// stimulus; an arithmetic sweep model predicts each cycle's outputs per instance.
module tb_dds_sweep_ctrl;
  localparam int DW = 4;
  localparam int G1 = 2;

  logic          clk = 1'b0;
  logic          rstn, start, stop, loop_s;
  logic [2:0]    sel_lo, sel_hi;
  logic [DW-1:0] dwell;

  logic [2:0] f_sel0, f_sel1;
  logic       en0, en1, busy0, busy1, stb0, stb1, done0, done1, err0, err1;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.DWELL_W(DW), .GAP_CYC(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .sel_lo(sel_lo),
    .sel_hi(sel_hi), .dwell(dwell), .loop(loop_s), .f_sel(f_sel0), .en(en0),
    .busy(busy0), .step_strobe(stb0), .done(done0), .err(err0));

  dds_sweep_ctrl #(.DWELL_W(DW), .GAP_CYC(G1)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .sel_lo(sel_lo),
    .sel_hi(sel_hi), .dwell(dwell), .loop(loop_s), .f_sel(f_sel1), .en(en1),
    .busy(busy1), .step_strobe(stb1), .done(done1), .err(err1));

  int     n_vec = 0;
  int     n_bad = 0;
  longint edge_n = 0;

  logic [7:0] expq0[$];
  logic [7:0] expq1[$];

  bit     m_act[2];
  longint m_t0[2];
  int     m_lo[2], m_hi[2], m_dw[2];
  bit     m_loop[2];

  function automatic logic [7:0] rec(longint f, bit e, bit b, bit s, bit dn, bit er);
    logic [2:0] f3;
    f3 = 3'(f);
    return {f3, e, b, s, dn, er};
  endfunction

  function automatic logic [7:0] obs(int d);
    if (d == 0) return {f_sel0, en0, busy0, stb0, done0, err0};
    return {f_sel1, en1, busy1, stb1, done1, err1};
  endfunction

  // Expected outputs right after the upcoming edge, from the sweep schedule:
  // step k occupies [k*(dwell+gap), k*(dwell+gap)+dwell) after acceptance.
  function automatic logic [7:0] model_step(int d);
    longint g, tp, n, p, k, r;
    g = (d == 0) ? 0 : G1;
    if (!rstn) begin
      m_act[d] = 1'b0;
      return '0;
    end
    if (m_act[d]) begin
      if (stop) begin
        m_act[d] = 1'b0;
        return '0;
      end
      tp = edge_n - m_t0[d];
      n  = m_hi[d] - m_lo[d] + 1;
      p  = m_dw[d] + g;
      if (!m_loop[d] && tp == n * p - g) begin
        m_act[d] = 1'b0;
        return rec(0, 0, 0, 0, 1, 0);
      end
      k = tp / p;
      r = tp % p;
      if (r < m_dw[d]) return rec(m_lo[d] + (k % n), 1, 1, r == 0, 0, 0);
      return rec(m_lo[d] + ((k + 1) % n), 0, 1, 0, 0, 0);
    end
    if (start && !stop) begin
      if (sel_lo > 3'd6 || sel_hi > 3'd6 || sel_lo > sel_hi || dwell == 0)
        return rec(0, 0, 0, 0, 0, 1);
      m_act[d]  = 1'b1;
      m_t0[d]   = edge_n;
      m_lo[d]   = int'(sel_lo);
      m_hi[d]   = int'(sel_hi);
      m_dw[d]   = int'(dwell);
      m_loop[d] = loop_s;
      return rec(sel_lo, 1, 1, 1, 0, 0);
    end
    return '0;
  endfunction

  task automatic tick();
    edge_n = edge_n + 1;
    expq0.push_back(model_step(0));
    expq1.push_back(model_step(1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic scramble();
    sel_lo = 3'($urandom_range(0, 7));
    sel_hi = 3'($urandom_range(0, 7));
    dwell  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom_range(0, 3));
    loop_s = 1'($urandom_range(0, 1));
  endtask

  task automatic go(int lo, int hi, int dw, bit lp);
    sel_lo = 3'(lo);
    sel_hi = 3'(hi);
    dwell  = DW'(dw);
    loop_s = lp;
    start  = 1'b1;
    tick();
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      tick();
    end
  endtask

  task automatic check_now(string name, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b (f_sel,en,busy,strobe,done,err)", name, got, exp);
    end
  endtask

  task automatic mon_pop(int d);
    logic [7:0] e;
    if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
      n_vec++;
      n_bad++;
      $display("FAIL dut%0d_noexp at t=%0t got=%b required=<queued entry>", d, $time, obs(d));
      return;
    end
    e = (d == 0) ? expq0.pop_front() : expq1.pop_front();
    n_vec++;
    if (obs(d) !== e) begin
      n_bad++;
      $display("FAIL dut%0d_out t=%0t got f_sel=%0d en=%b busy=%b stb=%b done=%b err=%b required f_sel=%0d en=%b busy=%b stb=%b done=%b err=%b",
               d, $time, obs(d)[7:5], obs(d)[4], obs(d)[3], obs(d)[2], obs(d)[1], obs(d)[0],
               e[7:5], e[4], e[3], e[2], e[1], e[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon_pop(0);
    mon_pop(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0;
    sel_lo = '0; sel_hi = '0; dwell = '0; loop_s = 1'b0;
    m_act = '{default: 1'b0};
    tick(); tick(); tick();
    rstn = 1'b1;
    idle_ticks(2);

    // basic sweep, with parameter churn and start pulses while running
    go(1, 3, 4, 0);
    for (int i = 1; i <= 11; i++) begin
      scramble();
      start = (i % 3 == 0);
      tick();
    end
    scramble();
    tick();
    // restart in the done cycle of the no-gap instance
    go(2, 2, 1, 0);
    idle_ticks(20);

    go(0, 1, 3, 0);
    idle_ticks(12);

    go(5, 6, 2, 1);
    idle_ticks(19);
    stop = 1'b1;
    tick();
    idle_ticks(4);

    go(4, 2, 3, 0);
    tick();
    go(1, 7, 3, 0);
    go(1, 2, 0, 0);
    sel_lo = 3'd1; sel_hi = 3'd2; dwell = DW'(3); start = 1'b1; stop = 1'b1;
    tick();
    idle_ticks(3);

    go(0, 1, 15, 0);
    idle_ticks(40);

    // asynchronous reset between edges mid-sweep
    go(0, 6, 3, 1);
    idle_ticks(5);
    #2 rstn = 1'b0;
    #1;
    check_now("async_rst_dut0", obs(0), 8'h00);
    check_now("async_rst_dut1", obs(1), 8'h00);
    tick();
    tick();
    rstn = 1'b1;
    idle_ticks(6);

    for (int i = 0; i < 3000; i++) begin
      scramble();
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle_ticks(2);

    if (expq0.size() != 0 || expq1.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain got=%0d/%0d left required=0", expq0.size(), expq1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS tone generator. It drives the generator's `f_sel` (3-bit step select, valid 0..6) and `en` inputs. On a start request it steps `f_sel` from a low bound to a high bound, holding each step for a programmable dwell time. Between steps it can insert an enable-low gap so the phase accumulator restarts at zero. The sweep runs once or loops until stopped.

## Interface
- `DWELL_W`, 16: width of the dwell counter and of the `dwell` input.
- `GAP_CYC`, 0: cycles with `en`=0 inserted between consecutive steps, including at the loop wrap; 0 means no gap.
- `clk` in 1: single clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `start` in 1: request pulse; sampled only in IDLE.
- `stop` in 1: abort request; level-sampled every cycle.
- `sel_lo` in 3: first step select; sampled with `start`.
- `sel_hi` in 3: last step select; sampled with `start`.
- `dwell` in DWELL_W: cycles per step with `en`=1; sampled with `start`.
- `loop` in 1: 1 = continuous sweep; sampled with `start`.
- `f_sel` out 3: step select to the DDS.
- `en` out 1: enable to the DDS.
- `busy` out 1: high in RUN and GAP.
- `step_strobe` out 1: 1-cycle pulse on the first RUN cycle of every step.
- `done` out 1: 1-cycle pulse when a non-loop sweep finishes naturally.
- `err` out 1: 1-cycle pulse when a start is rejected.

## Operation
- **State machine:** IDLE, RUN, GAP. All outputs are registered.
- **Reset values:** state IDLE; `f_sel`=0, `en`=0, `busy`=0, `step_strobe`=0, `done`=0, `err`=0; internal counters 0.
- **IDLE:**
  - Outputs: `en`=0, `f_sel`=0.
  - On `start`=1 and `stop`=0, validate the request.
  - Reject if `sel_lo`>6, `sel_hi`>6, `sel_lo`>`sel_hi`, or `dwell`==0. A rejected start pulses `err` next cycle and stays in IDLE.
  - Otherwise latch `sel_lo`, `sel_hi`, `dwell`, `loop`, set cur=`sel_lo`, and go to RUN.
- **RUN:**
  - Outputs: `en`=1, `f_sel`=cur.
  - The dwell counter counts 1..dwell; the step lasts exactly `dwell` cycles.
  - At the last cycle of a step, if cur<hi: cur=cur+1.
  - At the last cycle of a step, if cur==hi and loop=1: cur=lo.
  - At the last cycle of a step, if cur==hi and loop=0: go to IDLE and pulse `done`.
  - When continuing, go to GAP if `GAP_CYC`>0, otherwise stay in RUN with the new cur.
- **GAP:**
  - Outputs: `en`=0; `f_sel` already shows the next cur.
  - Lasts exactly `GAP_CYC` cycles, then goes to RUN.
- **Stop:**
  - `stop`=1 in RUN or GAP forces IDLE next cycle. No `done` pulse.
  - `stop` and `start` together in IDLE: stop wins; start is ignored, no `err`.
- **Parameter changes mid-sweep:** `sel_lo`, `sel_hi`, `dwell`, `loop` changes during a sweep have no effect. `start` during RUN/GAP is ignored.
- **Single-step sweep:** `sel_lo`==`sel_hi` is legal.
- **Dwell counter:** DWELL_W bits. `dwell`=2^DWELL_W−1 is legal; there is no wrap inside a step.

## Timing
- **Start:** `start` sampled at edge T (accepted). At T+1: `en`=1, `f_sel`=lo, `busy`=1, `step_strobe`=1.
- **Step boundaries:**
  - Step k (0-based) starts at T+1+k·(dwell+GAP_CYC).
  - `f_sel` changes on the same edge that `step_strobe` pulses when `GAP_CYC`=0.
  - When `GAP_CYC`>0, `f_sel` changes at gap entry.
- **Completion:** a non-loop sweep of N=hi−lo+1 steps gives `done`=1, `en`=0, `busy`=0, `f_sel`=0 at T+1+N·dwell+(N−1)·GAP_CYC, all in the same cycle.
- **Stop latency:** `stop` sampled at edge S gives `en`=0, `busy`=0, `f_sel`=0 at S+1.
- **Restart:** a new `start` is accepted in the cycle `done` is high, since the state is already IDLE.
- **Reject latency:** `err` goes high at T+1; `busy` stays 0.
- **Reset mid-sweep:** outputs go to reset values immediately (asynchronously). After `rstn` deasserts, the block sits in IDLE until the next start.

## Test plan
- **Basic sweep:** `GAP_CYC`=0, start with lo=1, hi=3, dwell=4, loop=0.
  - `f_sel` = 1,1,1,1,2,2,2,2,3,3,3,3 with `en`=1 for 12 cycles.
  - `step_strobe` at cycles 1, 5, 9.
  - `done` at cycle 13, with `en`=0.
- **Gap insertion:** `GAP_CYC`=2, lo=0, hi=1, dwell=3.
  - `en` pattern is 1,1,1,0,0,1,1,1.
  - `f_sel`=1 from the first gap cycle.
  - `done` one cycle after the last `en`=1.
- **Loop and stop:** loop=1, lo=5, hi=6, dwell=2.
  - `f_sel` = 5,5,6,6,5,5,6,… continuously.
  - `stop` on the 2nd cycle of a 6-step gives `en`=0, `f_sel`=0 next cycle and no `done`.
- **Rejects:** start with lo=4, hi=2 → `err` 1 cycle, `busy`=0.
  - Also check hi=7 → `err`, and dwell=0 → `err`.
  - `start`+`stop` together in IDLE → no `err`, stays IDLE.
- **Ignored inputs:** change `dwell`/`sel_hi` and pulse `start` during RUN → the sweep continues with the latched values.
  - Start again in the `done` cycle → accepted; `en`=1 next cycle.
- **Asynchronous reset:** assert `rstn`=0 mid-RUN, between clock edges.
  - `en`, `busy`, `f_sel` go to 0 immediately.
  - After release, no activity until `start`.
